bg_mem_arbiter: RTL and testbench

- Owns the single-port background RAM: 165x240 cells, 8-bit RRRGGGBB, address = y*165 + x.
- Shares that RAM between three requesters:
  - the VGA renderer's per-pixel background fetch, which is never stalled;
  - a game-logic write port with a valid/ready handshake and a small FIFO;
  - a built-in fill engine that clears or paints the whole background.
- Sits between the render path and the background RAM macro.

---
 rtl/bg_pkg.sv | 22 ++
 rtl/bg_wr_fifo.sv | 58 +++++
 rtl/bg_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_bg_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Background plane geometry, bus widths and arbiter state encoding shared by the
// arbiter and the render address math.
package bg_pkg;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int BG_PIX_W = 165;
  localparam int BG_PIX_H = 240;
  localparam int BG_SIZE  = BG_PIX_W * BG_PIX_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } bg_state_e;

  // Row-major cell address: y*165 + x.
  function automatic logic [ADDR_W-1:0] bg_cell_addr(input logic [7:0] x, input logic [7:0] y);
    return ADDR_W'(BG_PIX_W * int'(y) + int'(x));
  endfunction

endpackage

// File: rtl/bg_wr_fifo.sv
// In-order queue of pending background writes; head is visible the cycle after the push.
// Pushes when full and pops when empty are ignored, so the owner gates both with full/empty.
module bg_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bg_mem_arbiter.sv
// Shares the single-port background RAM between render reads, queued writes and a fill engine.
// Render reads return data 1 cycle later and are never stalled; writes and fill only use idle cycles.
module bg_mem_arbiter #(
  parameter int ADDR_W     = bg_pkg::ADDR_W,
  parameter int DATA_W     = bg_pkg::DATA_W,
  parameter int BG_SIZE    = bg_pkg::BG_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_data_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import bg_pkg::*;

  localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(BG_SIZE);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BG_SIZE - 1);
  localparam int                ENT_W  = ADDR_W + DATA_W;

  bg_state_e         state;
  bg_state_e         state_nxt;
  logic [ADDR_W-1:0] fill_ptr;
  logic [ADDR_W-1:0] fill_ptr_nxt;
  logic [DATA_W-1:0] fill_val;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_legal;
  logic              we_raw;

  assign wr_ready   = (state == IDLE) & ~fifo_full & rst_n;
  assign push       = wr_valid & wr_ready;
  // The queue is empty by construction once FILL is reached, so only IDLE/DRAIN pop.
  assign pop        = ~vga_req & (state != FILL) & ~fifo_empty;
  assign {head_addr, head_data} = head;
  assign head_legal = (head_addr < SIZE_A);

  assign vga_data  = mem_rdata;
  assign fill_busy = (state != IDLE);
  assign mem_we    = we_raw & rst_n;

  bg_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    we_raw    = 1'b0;
    if (vga_req) begin
      mem_addr = vga_addr;
    end else if (state == FILL) begin
      mem_addr  = fill_ptr;
      mem_wdata = fill_val;
      we_raw    = 1'b1;
    end else if (!fifo_empty && head_legal) begin
      mem_addr  = head_addr;
      mem_wdata = head_data;
      we_raw    = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    fill_ptr_nxt = fill_ptr;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_nxt    = FILL;
          fill_ptr_nxt = '0;
        end
      end
      FILL: begin
        if (!vga_req) begin
          if (fill_ptr == LAST_A) begin
            state_nxt = IDLE;
          end else begin
            fill_ptr_nxt = fill_ptr + ADDR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      fill_ptr       <= '0;
      fill_val       <= '0;
      vga_data_valid <= 1'b0;
      wr_drop        <= 1'b0;
    end else begin
      state          <= state_nxt;
      fill_ptr       <= fill_ptr_nxt;
      vga_data_valid <= vga_req;
      wr_drop        <= pop & ~head_legal;
      if (state == IDLE && fill_start) begin
        fill_val <= fill_value;
      end
    end
  end

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Directed bench for bg_mem_arbiter with a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_bg_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic [7:0]  vga_data;
  logic        vga_data_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_drop;
  logic        fill_start;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int nvec;
  int nbad;

  bg_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vga_req        (vga_req),
    .vga_addr       (vga_addr),
    .vga_data       (vga_data),
    .vga_data_valid (vga_data_valid),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_drop        (wr_drop),
    .fill_start     (fill_start),
    .fill_value     (fill_value),
    .fill_busy      (fill_busy),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Background RAM: synchronous read of the old contents, preloaded with a known pattern.
  logic [7:0] ram [65536];
  bit         ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram_ready <= 1'b1;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes as a queue, fill as mode + cell counter.
  logic [23:0] m_q [$];
  int          m_mode;  // 0 idle, 1 waiting for queue to drain, 2 filling
  logic [15:0] m_ptr;
  logic [7:0]  m_fval;
  logic        m_vdv;
  logic        m_drop;
  logic [7:0]  m_rd;
  logic [7:0]  m_ram [65536];
  bit          m_init;
  bit          armed;

  always @(negedge clk) begin
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_we;
    logic        e_ready;
    logic        do_pop;
    logic        ill;
    if (!m_init) begin
      for (int i = 0; i < 65536; i++) m_ram[i] = 8'(i) ^ 8'h5A;
      m_init = 1'b1;
    end
    e_ready = rst_n && (m_mode == 0) && (m_q.size() < 4);
    e_addr = 16'h0; e_wd = 8'h0; e_we = 1'b0; do_pop = 1'b0; ill = 1'b0;
    if (vga_req) begin
      e_addr = vga_addr;
    end else if (m_mode == 2) begin
      e_addr = m_ptr; e_wd = m_fval; e_we = 1'b1;
    end else if (m_q.size() > 0) begin
      do_pop = 1'b1;
      if (m_q[0][23:8] < 16'd39600) begin
        e_addr = m_q[0][23:8]; e_wd = m_q[0][7:0]; e_we = 1'b1;
      end else begin
        ill = 1'b1;
      end
    end
    if (!rst_n) e_we = 1'b0;
    if (armed) begin
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("wr_ready", 32'(wr_ready), 32'(e_ready));
      chk("fill_busy", 32'(fill_busy), 32'(m_mode != 0));
      chk("vga_data_valid", 32'(vga_data_valid), 32'(m_vdv));
      chk("wr_drop", 32'(wr_drop), 32'(m_drop));
      if (m_vdv) chk("vga_data", 32'(vga_data), 32'(m_rd));
    end
    m_rd = m_ram[e_addr];
    if (e_we) m_ram[e_addr] = e_wd;
    if (!rst_n) begin
      m_q.delete();
      m_mode = 0; m_ptr = 16'h0; m_fval = 8'h0;
      m_vdv = 1'b0; m_drop = 1'b0;
      armed = 1'b1;
    end else begin
      case (m_mode)
        0: if (fill_start) begin m_mode = 1; m_fval = fill_value; end
        1: if (m_q.size() == 0) begin m_mode = 2; m_ptr = 16'h0; end
        2: if (!vga_req) begin
             if (m_ptr == 16'd39599) m_mode = 0;
             else m_ptr = m_ptr + 16'd1;
           end
        default: m_mode = 0;
      endcase
      if (do_pop) void'(m_q.pop_front());
      if (wr_valid && e_ready) m_q.push_back({wr_addr, wr_data});
      m_vdv  = vga_req;
      m_drop = ill;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_n;
    int rdy_bad;
    int i;
    bit done;
    rst_n = 1'b0; vga_req = 1'b0; vga_addr = 16'h0;
    wr_valid = 1'b0; wr_addr = 16'h0; wr_data = 8'h0;
    fill_start = 1'b0; fill_value = 8'h0;

    // Reset
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    cyc();
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("post_rst_fill_busy", 32'(fill_busy), 32'd0);
    chk("post_rst_vdv", 32'(vga_data_valid), 32'd0);

    // Render read beats a queued write
    cyc(); vga_req = 1'b1; vga_addr = 16'h0100; wr_valid = 1'b1; wr_addr = 16'd5; wr_data = 8'hE0;
    @(negedge clk);
    chk("prio_addr", 32'(mem_addr), 32'h0100);
    chk("prio_we", 32'(mem_we), 32'd0);
    cyc(); vga_req = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("prio_vdv", 32'(vga_data_valid), 32'd1);
    chk("prio_vdata", 32'(vga_data), 32'h5A);
    chk("prio_wr_addr", 32'(mem_addr), 32'd5);
    chk("prio_wr_data", 32'(mem_wdata), 32'hE0);
    cyc();

    // FIFO fills while render holds the RAM
    vga_req = 1'b1; vga_addr = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_addr = 16'(16'h10 + k); wr_data = 8'(8'h11 + k);
      cyc();
    end
    wr_addr = 16'h14; wr_data = 8'h15;
    @(negedge clk);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    cyc(); vga_req = 1'b0;
    @(negedge clk);
    chk("pop1_addr", 32'(mem_addr), 32'h10);
    chk("pop1_data", 32'(mem_wdata), 32'h11);
    chk("pop1_no_bypass", 32'(wr_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("pop2_addr", 32'(mem_addr), 32'h11);
    chk("pop2_wr_ready", 32'(wr_ready), 32'd1);
    cyc(); wr_valid = 1'b0;
    @(negedge clk); chk("pop3_addr", 32'(mem_addr), 32'h12);
    cyc();
    @(negedge clk); chk("pop4_addr", 32'(mem_addr), 32'h13);
    cyc();
    @(negedge clk); chk("pop5_data", 32'(mem_wdata), 32'h15);
    cyc();

    // Out-of-range write is dropped, the next legal one lands
    wr_valid = 1'b1; wr_addr = 16'd39600; wr_data = 8'hAA;
    cyc(); wr_addr = 16'd39599; wr_data = 8'hBB;
    @(negedge clk);
    chk("ill_pop_we", 32'(mem_we), 32'd0);
    cyc(); wr_valid = 1'b0;
    @(negedge clk);
    chk("ill_drop", 32'(wr_drop), 32'd1);
    chk("last_legal_addr", 32'(mem_addr), 32'd39599);
    chk("last_legal_we", 32'(mem_we), 32'd1);
    cyc();
    @(negedge clk); chk("drop_once", 32'(wr_drop), 32'd0);
    cyc();

    // Full fill behind two queued writes
    vga_req = 1'b1; vga_addr = 16'h0;
    wr_valid = 1'b1; wr_addr = 16'h20; wr_data = 8'h31;
    cyc(); wr_addr = 16'h21; wr_data = 8'h32;
    cyc(); wr_valid = 1'b0; vga_req = 1'b0; fill_start = 1'b1; fill_value = 8'h1C;
    @(negedge clk);
    chk("fill_q1_addr", 32'(mem_addr), 32'h20);
    chk("fill_q1_data", 32'(mem_wdata), 32'h31);
    cyc(); fill_start = 1'b0;
    busy_n = 0; rdy_bad = 0; i = 0; done = 1'b0;
    while (i < 50000 && !done) begin
      @(negedge clk);
      if (!fill_busy) begin
        done = 1'b1;
      end else begin
        busy_n++;
        if (wr_ready) rdy_bad++;
        if (i == 0) chk("fill_q2_addr", 32'(mem_addr), 32'h21);
        if (i == 2) begin
          chk("fill_first_addr", 32'(mem_addr), 32'd0);
          chk("fill_first_data", 32'(mem_wdata), 32'h1C);
        end
        if (i == 39601) chk("fill_last_addr", 32'(mem_addr), 32'd39599);
        i++;
      end
    end
    chk("fill_busy_cycles", 32'(busy_n), 32'd39602);
    chk("fill_wr_ready_high", 32'(rdy_bad), 32'd0);
    chk("ram0", 32'(ram[0]), 32'h1C);
    chk("ram20", 32'(ram[16'h20]), 32'h1C);
    chk("ram_last", 32'(ram[39599]), 32'h1C);
    chk("ram_beyond", 32'(ram[39600]), 32'hEA);
    cyc();

    // Fill under 1:1 render traffic, reset when the pointer reaches 1000
    fill_start = 1'b1; fill_value = 8'h03;
    cyc(); fill_start = 1'b0;
    cyc();
    for (int off = 0; off <= 2000; off++) begin
      vga_req = off[0];
      vga_addr = 16'(off * 7);
      if (off == 2000) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ptr_addr", 32'(mem_addr), 32'd1000);
        chk("rst_fill_we", 32'(mem_we), 32'd0);
      end
      cyc();
    end
    vga_req = 1'b0;
    @(negedge clk);
    chk("rst_fill_busy", 32'(fill_busy), 32'd0);
    chk("rst_hold_we", 32'(mem_we), 32'd0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rerun_wr_ready", 32'(wr_ready), 32'd1);
    chk("ram999", 32'(ram[999]), 32'h03);
    chk("ram1000", 32'(ram[1000]), 32'h1C);

    // New fill restarts at cell 0
    cyc(); fill_start = 1'b1; fill_value = 8'h55;
    cyc(); fill_start = 1'b0;
    cyc();
    @(negedge clk);
    chk("refill_addr0", 32'(mem_addr), 32'd0);
    chk("refill_data", 32'(mem_wdata), 32'h55);
    cyc();
    @(negedge clk);
    chk("refill_addr1", 32'(mem_addr), 32'd1);
    cyc(); rst_n = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
